shmem_initiator: RTL and testbench



---
 rtl/shmem_pkg.sv | 23 ++
 rtl/shmem_initiator_if.sv | 42 ++++
 rtl/shmem_initiator_rr_arbiter.sv | 48 ++++
 rtl/shmem_initiator.sv | 109 ++++++++++
 tb/tb_shmem_initiator.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shmem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : shmem_pkg                                                  |
// | Description : Shared constants and the response-tag type for the        |
// |               shared-memory requester front end.                         |
// | Revision    : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
package shmem_pkg;

  localparam int ADDR_W     = 8;    // word address width
  localparam int DATA_W     = 32;   // data word width
  localparam int MEM_WORDS  = 256;  // words in the attached memory
  localparam int TAG_LANES  = 4;    // lane count the response tag is sized for
  localparam int TAG_LANE_W = $clog2(TAG_LANES);

  // Travels alongside an issued request so the read data can be routed back.
  typedef struct packed {
    logic [TAG_LANE_W-1:0] lane;
    logic                  is_read;
  } rsp_tag_t;

endpackage
`default_nettype wire

// File: rtl/shmem_initiator_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : shmem_initiator_if                                         |
// | Description : Lane request/response and memory-port bundle for the      |
// |               shared-memory initiator.                                   |
// | Revision    : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
interface shmem_initiator_if #(
  parameter int NUM_LANES = shmem_pkg::TAG_LANES,
  parameter int ADDR_W    = shmem_pkg::ADDR_W,
  parameter int DATA_W    = shmem_pkg::DATA_W
);

  // lane side
  logic [NUM_LANES-1:0]        req_valid;
  logic [NUM_LANES-1:0]        req_ready;
  logic [NUM_LANES-1:0]        req_we;
  logic [NUM_LANES*ADDR_W-1:0] req_addr;
  logic [NUM_LANES*DATA_W-1:0] req_wdata;
  logic [NUM_LANES-1:0]        rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;

  // memory side
  logic [31:0]                 mem_addr;
  logic [DATA_W-1:0]           mem_data_in;
  logic                        mem_we;
  logic [DATA_W-1:0]           mem_data_out;

  // The initiator itself.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_data_in, mem_we
  );

  // Lanes plus memory, as seen from outside the initiator.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_data_in, mem_we
  );

endinterface
`default_nettype wire

// File: rtl/shmem_initiator_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : rr_arbiter                                                 |
// | Description : Round-robin arbiter. The pointer holds the most recently  |
// |               granted requester; search starts one past it.              |
// | Revision    : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] last;
  logic [PTR_W-1:0] win;
  int               idx;

  // Pick the first requester after the pointer, wrapping around.
  always_comb begin
    grant = '0;
    win   = last;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if ((grant == '0) && req[idx]) begin
        grant[idx] = 1'b1;
        win        = PTR_W'(idx);
      end
    end
  end

  // Pointer moves only when the granted request is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PTR_W'(N - 1);
    end else if (advance) begin
      last <= win;
    end
  end

endmodule
`default_nettype wire

// File: rtl/shmem_initiator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : shmem_initiator                                            |
// | Description : Arbitrates lane load/store requests onto one memory port, |
// |               registers the issue stage and routes read data back.      |
// | Revision    : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
module shmem_initiator #(
  parameter int NUM_LANES = shmem_pkg::TAG_LANES,
  parameter int ADDR_W    = shmem_pkg::ADDR_W,
  parameter int DATA_W    = shmem_pkg::DATA_W
) (
  input logic              clk,
  input logic              rst,
  shmem_initiator_if.slave bus
);

  import shmem_pkg::*;

  localparam int LANE_W = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0] w_grant;
  logic [NUM_LANES-1:0] w_ready;
  logic                 w_xfer;
  logic [LANE_W-1:0]    w_sel_lane;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;
  logic                 w_sel_we;
  logic [NUM_LANES-1:0] w_rsp_next;

  logic [31:0]          r_mem_addr;
  logic [DATA_W-1:0]    r_mem_data_in;
  logic                 r_mem_we;
  rsp_tag_t             r_tag;
  logic [NUM_LANES-1:0] r_rsp_valid;

  rr_arbiter #(
    .N (NUM_LANES)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (w_xfer),
    .grant   (w_grant)
  );

  // Nothing is accepted while reset is held.
  assign w_ready = rst ? '0 : w_grant;
  assign w_xfer  = |(w_ready & bus.req_valid);

  // Encode the one-hot grant into a lane index for the request mux.
  always_comb begin
    w_sel_lane = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_grant[i]) begin
        w_sel_lane = LANE_W'(i);
      end
    end
  end

  assign w_sel_addr  = bus.req_addr[w_sel_lane*ADDR_W +: ADDR_W];
  assign w_sel_wdata = bus.req_wdata[w_sel_lane*DATA_W +: DATA_W];
  assign w_sel_we    = bus.req_we[w_sel_lane];

  // Issue stage: address/data hold when idle so the memory sees a quiet bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
      r_mem_we      <= 1'b0;
      r_tag         <= '0;
    end else if (w_xfer) begin
      r_mem_addr    <= 32'(w_sel_addr);
      r_mem_data_in <= w_sel_wdata;
      r_mem_we      <= w_sel_we;
      r_tag.lane    <= TAG_LANE_W'(w_sel_lane);
      r_tag.is_read <= ~w_sel_we;
    end else begin
      r_mem_we      <= 1'b0;
      r_tag         <= '0;
    end
  end

  // Decode the issued tag into the owning lane's strobe.
  always_comb begin
    w_rsp_next = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_rsp_next[i] = r_tag.is_read && (int'(r_tag.lane) == i);
    end
  end

  // Response stage lines up with the memory's registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
    end else begin
      r_rsp_valid <= w_rsp_next;
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_data_in = r_mem_data_in;
  assign bus.mem_we      = r_mem_we;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = bus.mem_data_out;

endmodule
`default_nettype wire

// File: tb/tb_shmem_initiator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : tb_shmem_initiator                                         |
// | Description : Self-checking bench for shmem_initiator with a behavioural|
// |               registered-read memory and a response scoreboard.          |
// | Revision    : 1.0 - initial release                                      |
// ---------------------------------------------------------------------------
module tb_shmem_initiator;

  localparam int NL = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    int          due;
    int          lane;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [0:shmem_pkg::MEM_WORDS-1];
  logic [31:0] mem_arr   [0:shmem_pkg::MEM_WORDS-1];

  shmem_initiator_if #(.NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW)) bus ();

  shmem_initiator #(.NUM_LANES(NL), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: write on we, registered read of the presented address.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) mem_arr[bus.mem_addr[7:0]] <= bus.mem_data_in;
    bus.mem_data_out <= mem_arr[bus.mem_addr[7:0]];
  end

  initial begin
    for (int i = 0; i < shmem_pkg::MEM_WORDS; i++) begin
      mem_arr[i]   = 32'(i + 1);
      model_mem[i] = 32'(i + 1);
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [NL-1:0] oh;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e  = sb.pop_front();
        oh = NL'(1) << e.lane;
        total++;
        if (bus.rsp_valid !== oh || bus.rsp_rdata !== e.data) begin
          bad++;
          $display("FAIL sb_rsp cyc=%0d got valid=%b data=%h want valid=%b data=%h",
                   cyc, bus.rsp_valid, bus.rsp_rdata, oh, e.data);
        end
      end else begin
        total++;
        if (bus.rsp_valid !== '0) begin
          bad++;
          $display("FAIL sb_idle_rsp cyc=%0d got valid=%b want 0", cyc, bus.rsp_valid);
        end
      end
      if (rst) begin
        total++;
        if (bus.req_ready !== '0) begin
          bad++;
          $display("FAIL sb_ready_in_rst cyc=%0d got %b want 0", cyc, bus.req_ready);
        end
        sb.delete();
      end else begin
        for (int i = 0; i < NL; i++) begin
          if (bus.req_valid[i] && bus.req_ready[i]) begin
            logic [7:0] a;
            a = bus.req_addr[i*AW +: AW];
            if (bus.req_we[i]) model_mem[a] = bus.req_wdata[i*DW +: DW];
            else sb.push_back('{due: cyc + 2, lane: i, data: model_mem[a]});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic v, input logic we,
                          input logic [7:0] a, input logic [31:0] d);
    bus.req_valid[i]          = v;
    bus.req_we[i]             = we;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) step();
    total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got %b want 0000", bus.req_ready); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got %b want 0", bus.mem_we); end
    total++; if (bus.mem_addr !== 32'd0) begin bad++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); end
    total++; if (bus.mem_data_in !== 32'd0) begin bad++; $display("FAIL rst_mem_data_in got %h want 0", bus.mem_data_in); end
    total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL rst_rsp_valid got %b want 0000", bus.rsp_valid); end
    bus.req_valid = '0;
    mon_en = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    set_lane(2, 1'b1, 1'b0, 8'd5, 32'd0);
    #1;
    total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got %b want 0100", bus.req_ready); end
    step();
    set_lane(2, 1'b0, 1'b0, 8'd0, 32'd0);
    total++; if (bus.mem_addr !== 32'd5 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL single_issue got addr=%h we=%b want 5/0", bus.mem_addr, bus.mem_we); end
    step();
    total++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_rdata !== 32'd6) begin bad++; $display("FAIL single_rsp got %b/%h want 0100/6", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  task automatic test_write_then_read();
    set_lane(0, 1'b1, 1'b1, 8'd20, 32'hDEADBEEF);
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL wr_ready got %b want 0001", bus.req_ready); end
    step();
    set_lane(0, 1'b0, 1'b0, 8'd0, 32'd0);
    set_lane(1, 1'b1, 1'b0, 8'd20, 32'd0);
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL rd_ready got %b want 0010", bus.req_ready); end
    total++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'd20 || bus.mem_data_in !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wr_issue got we=%b addr=%h data=%h want 1/14/deadbeef", bus.mem_we, bus.mem_addr, bus.mem_data_in);
    end
    step();
    set_lane(1, 1'b0, 1'b0, 8'd0, 32'd0);
    total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL wr_no_rsp got %b want 0000", bus.rsp_valid); end
    step();
    total++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_rsp got %b/%h want 0010/deadbeef", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  task automatic test_fairness();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NL; i++) set_lane(i, 1'b1, 1'b0, 8'(i), 32'd0);
    for (int k = 0; k < NL; k++) begin
      logic [NL-1:0] want;
      want = NL'(1) << k;
      #1;
      total++; if (bus.req_ready !== want) begin bad++; $display("FAIL fair_grant%0d got %b want %b", k, bus.req_ready, want); end
      step();
      set_lane(k, 1'b0, 1'b0, 8'd0, 32'd0);
    end
    total++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_rdata !== 32'd3) begin bad++; $display("FAIL fair_rsp2 got %b/%h want 0100/3", bus.rsp_valid, bus.rsp_rdata); end
    step();
    total++; if (bus.rsp_valid !== 4'b1000 || bus.rsp_rdata !== 32'd4) begin bad++; $display("FAIL fair_rsp3 got %b/%h want 1000/4", bus.rsp_valid, bus.rsp_rdata); end
    step();
  endtask

  task automatic test_rotation();
    set_lane(1, 1'b1, 1'b0, 8'd7, 32'd0);
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL rot_solo got %b want 0010", bus.req_ready); end
    step();
    set_lane(1, 1'b1, 1'b0, 8'd8, 32'd0);
    set_lane(3, 1'b1, 1'b0, 8'd9, 32'd0);
    #1;
    total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL rot_first got %b want 1000", bus.req_ready); end
    step();
    set_lane(3, 1'b0, 1'b0, 8'd0, 32'd0);
    #1;
    total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL rot_second got %b want 0010", bus.req_ready); end
    step();
    set_lane(1, 1'b0, 1'b0, 8'd0, 32'd0);
    repeat (3) step();
  endtask

  task automatic test_reset_midflight();
    // a write on the memory bus during reset still lands
    set_lane(0, 1'b1, 1'b1, 8'd40, 32'h12345678);
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mf_wr_ready got %b want 0001", bus.req_ready); end
    step();
    set_lane(0, 1'b0, 1'b0, 8'd0, 32'd0);
    rst = 1'b1;
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL mf_wr_on_bus got %b want 1", bus.mem_we); end
    step();
    rst = 1'b0;
    step();
    // an in-flight read is dropped by reset
    set_lane(0, 1'b1, 1'b0, 8'd30, 32'd0);
    step();
    set_lane(0, 1'b0, 1'b0, 8'd0, 32'd0);
    rst = 1'b1;
    step();
    total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL mf_rsp_dropped got %b want 0000", bus.rsp_valid); end
    total++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'd0) begin bad++; $display("FAIL mf_issue_cleared got we=%b addr=%h want 0/0", bus.mem_we, bus.mem_addr); end
    rst = 1'b0;
    for (int i = 0; i < NL; i++) set_lane(i, 1'b1, 1'b0, 8'd40, 32'd0);
    #1;
    total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mf_lane0_first got %b want 0001", bus.req_ready); end
    step();
    for (int i = 0; i < NL; i++) set_lane(i, 1'b0, 1'b0, 8'd0, 32'd0);
    step();
    total++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata !== 32'h12345678) begin bad++; $display("FAIL mf_write_kept got %b/%h want 0001/12345678", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if (bus.mem_we !== 1'b0 || bus.rsp_valid !== 4'b0000 || bus.mem_addr !== 32'd40) begin
        bad++;
        $display("FAIL idle%0d got we=%b rsp=%b addr=%h want 0/0000/28", k, bus.mem_we, bus.rsp_valid, bus.mem_addr);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_single_read();
    test_write_then_read();
    test_fairness();
    test_rotation();
    test_reset_midflight();
    test_idle();
    repeat (3) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got %0d outstanding want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
